cram_wr_arb: RTL and testbench
==============================

# cram_wr_arb

Write-port controller for the 256×15 colour RAM (CRAM) that feeds the video-out palette lookup. Shares the single CRAM write port between Z80 palette writes (strobe-only, must never be lost silently) and a palette DMA stream (valid/ready). Optionally sweeps a default grey-ramp palette into CRAM after reset. Sits between the CPU/DMA fabric and the CRAM `cram_addr_in`/`cram_data_in`/`cram_we` inputs of the video output stage.

## Interface
Parameters:
- none; widths come from the shared package.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_we`  in  1  one-cycle CPU palette write strobe.
- `cpu_addr`  in  8  CRAM entry index for the CPU write.
- `cpu_data`  in  15  RGB555 word for the CPU write.
- `dma_req`  in  1  DMA write valid.
- `dma_addr`  in  8  CRAM entry index for the DMA write.
- `dma_data`  in  15  RGB555 word for the DMA write.
- `dma_rdy`  out  1  DMA write ready; a transfer happens on an edge where `dma_req` and `dma_rdy` are both 1.
- `cram_we`  out  1  registered CRAM write enable.
- `cram_addr`  out  8  registered CRAM address.
- `cram_data`  out  15  registered CRAM data.
- `init_done`  out  1  default-palette sweep finished.
- `cpu_ovf`  out  1  sticky flag: a CPU write was dropped.
- `busy`  out  1  sweep running or CPU FIFO non-empty.

## Operation
- FSM states:
  - INIT: default-palette sweep.
  - RUN: normal arbitration.
  - Reset enters INIT when `CRAM_INIT_EN` is defined, otherwise RUN.
  - INIT→RUN on the edge that issues entry 255. No other transitions.
- CPU path: `cpu_we` pushes {addr, data} into a 2-entry FIFO in all states.
  - Push while full: write dropped, FIFO unchanged, `cpu_ovf` set to 1 until reset.
  - Push and pop on the same edge with the FIFO full: the push is accepted.
- Issue stage (RUN): at most one CRAM write per cycle. Priority:
  1. FIFO head, which is popped.
  2. Accepted DMA transfer.
- `dma_rdy` = (state==RUN) && (FIFO count==0). It is combinational from registers only, with no dependency on `cpu_we` or `dma_req`.
- `cpu_we` and a DMA transfer on the same edge with the FIFO empty: DMA issues on that edge; the CPU entry issues on the next edge.
- With no write issued, `cram_we`=0. `cram_addr`/`cram_data` hold their last values.
- INIT sweep: 8-bit counter i from 0 to 255, one write per cycle.
  - Data = {i[4:0], i[4:0], i[4:0]}; address = i.
  - `dma_rdy`=0 throughout INIT.
  - CPU writes queue in the FIFO and drain in RUN; overflow rules apply.
- `busy` = (state==INIT) || (FIFO count!=0).

## Timing
- Reset values: `cram_we`=0, `cram_addr`=0, `cram_data`=0, `cpu_ovf`=0, FIFO empty, sweep counter=0. `dma_rdy`=0 if `CRAM_INIT_EN` is defined, else 1. `init_done`=0 if `CRAM_INIT_EN` is defined, else 1.
- DMA latency: transfer accepted at edge k → `cram_we`=1 with that addr/data during the cycle after edge k.
- CPU latency, uncontended: `cpu_we` sampled at edge k → entry in FIFO after k → `cram_we`=1 after edge k+1 (2 cycles).
- Worst-case CPU latency in RUN: 3 edges, because DMA is gated while the FIFO is non-empty.
- Sweep: 256 consecutive `cram_we` cycles starting after the first edge following reset release.
  - `init_done` rises on the same edge that issues entry 255.
  - `dma_rdy` may rise on that edge if the FIFO is empty.
- Reset asserted mid-sweep or mid-burst: all state clears immediately and asynchronously. `cram_we` drops to 0 with no partial write. The sweep restarts from entry 0.
- Sustained throughput: 1 write/cycle.

## Configuration
- `CRAM_INIT_EN` defined:
  - INIT state, sweep counter and grey-ramp generator are compiled in.
  - `init_done` resets to 0.
- `CRAM_INIT_EN` undefined:
  - No INIT logic; FSM is RUN only.
  - `init_done` is constant 1.
  - CRAM contents after reset come from the memory init file only.

## Structure
- Package `cram_arb_pkg`:
  - `CRAM_AW`=8, `CRAM_DW`=15, `CPU_FIFO_DEPTH`=2.
  - State enum {ST_INIT, ST_RUN}.
  - Packed struct `cram_wr_t` {addr, data}.
- Sub-module `cram_wfifo`: 2-entry synchronous FIFO of `cram_wr_t` with push, pop, full, empty and count. It has no overflow handling; drop and `cpu_ovf` logic live in the parent.
- Top level `cram_wr_arb`: FSM, sweep counter, issue mux, output registers.

## Test plan
- Reset release with `CRAM_INIT_EN` → 256 writes, addr 0..255, data at addr 0x25 = 0x14A5; `init_done` rises with entry 255; `dma_rdy` low until then.
- RUN, FIFO empty, `cpu_we` addr 0x10 data 0x7FFF at edge k → `cram_we` addr 0x10 data 0x7FFF in the cycle after edge k+1, and no other write.
- DMA burst of 8 words with `dma_req` held high → 8 back-to-back `cram_we` cycles, each one cycle after acceptance, with addresses in order.
- `cpu_we` on the same edge as a DMA acceptance → DMA write first, CPU write on the next cycle; `dma_rdy` low while the FIFO is non-empty.
- Three `cpu_we` on consecutive edges during INIT → first two drain after `init_done` in order; third dropped; `cpu_ovf`=1 and stays 1.
- Assert `rst` at sweep entry 100 → `cram_we` drops to 0 asynchronously; after release the sweep restarts at addr 0.

Source files
------------

// File: rtl/cram_wr_arb_pkg.sv
// rtl/cram_wr_arb_pkg.sv - shared widths, state enum and write record for the CRAM write arbiter
package cram_arb_pkg;

  localparam int CRAM_AW        = 8;
  localparam int CRAM_DW        = 15;
  localparam int CPU_FIFO_DEPTH = 2;
  localparam int FIFO_PW        = $clog2(CPU_FIFO_DEPTH);
  localparam int FIFO_CW        = $clog2(CPU_FIFO_DEPTH + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic [CRAM_AW-1:0] addr;
    logic [CRAM_DW-1:0] data;
  } cram_wr_t;

  // Grey ramp: the low five index bits replicated into R, G and B.
  function automatic logic [CRAM_DW-1:0] grey_word(input logic [CRAM_AW-1:0] idx);
    return {idx[4:0], idx[4:0], idx[4:0]};
  endfunction

endpackage

// File: rtl/cram_wr_arb_wfifo.sv
// rtl/cram_wr_arb_wfifo.sv - small synchronous FIFO of CRAM write records (no overflow handling)
module cram_wfifo
  import cram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  cram_wr_t           din,
  output cram_wr_t           dout,
  output logic               full,
  output logic               empty,
  output logic [FIFO_CW-1:0] count
);

  cram_wr_t           mem [CPU_FIFO_DEPTH];
  logic [FIFO_PW-1:0] rd_ptr;
  logic [FIFO_PW-1:0] wr_ptr;
  logic               do_push;
  logic               do_pop;

  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == FIFO_CW'(CPU_FIFO_DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cram_wr_arb.sv
// rtl/cram_wr_arb.sv - CRAM write-port arbiter: CPU FIFO over DMA, optional grey-ramp sweep (CRAM_INIT_EN)
module cram_wr_arb
  import cram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_we,
  input  logic [CRAM_AW-1:0] cpu_addr,
  input  logic [CRAM_DW-1:0] cpu_data,
  input  logic               dma_req,
  input  logic [CRAM_AW-1:0] dma_addr,
  input  logic [CRAM_DW-1:0] dma_data,
  output logic               dma_rdy,
  output logic               cram_we,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [CRAM_DW-1:0] cram_data,
  output logic               init_done,
  output logic               cpu_ovf,
  output logic               busy
);

  state_t             state;
  cram_wr_t           cpu_wr;
  cram_wr_t           fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;
  logic               fifo_push;
  logic               fifo_pop;
  logic               dma_fire;

  assign cpu_wr = '{addr: cpu_addr, data: cpu_data};

  // The FIFO head always wins the port in RUN; DMA is held off until it is empty,
  // which bounds CPU latency without ever dropping a queued entry.
  assign fifo_pop  = (state == ST_RUN) && !fifo_empty;
  assign fifo_push = cpu_we && (!fifo_full || fifo_pop);
  assign dma_rdy   = (state == ST_RUN) && (fifo_count == '0);
  assign dma_fire  = dma_req && dma_rdy;
  assign busy      = (state == ST_INIT) || (fifo_count != '0);
  assign init_done = (state == ST_RUN);

  cram_wfifo u_wfifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (cpu_wr),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef CRAM_INIT_EN
  logic [CRAM_AW-1:0] sweep_idx;

  // Sweep FSM: walk every entry once after reset, then hand the port to arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_idx <= '0;
    end else if (state == ST_INIT) begin
      sweep_idx <= sweep_idx + 1'b1;
      if (sweep_idx == '1) state <= ST_RUN;
    end
  end
`else
  assign state = ST_RUN;
`endif

  // Issue stage: one registered CRAM write per cycle; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cram_we   <= 1'b0;
      cram_addr <= '0;
      cram_data <= '0;
    end else begin
      cram_we <= 1'b0;
`ifdef CRAM_INIT_EN
      if (state == ST_INIT) begin
        cram_we   <= 1'b1;
        cram_addr <= sweep_idx;
        cram_data <= grey_word(sweep_idx);
      end else
`endif
      if (fifo_pop) begin
        cram_we   <= 1'b1;
        cram_addr <= fifo_head.addr;
        cram_data <= fifo_head.data;
      end else if (dma_fire) begin
        cram_we   <= 1'b1;
        cram_addr <= dma_addr;
        cram_data <= dma_data;
      end
    end
  end

  // Sticky record that a CPU write found the FIFO full and was discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      cpu_ovf <= 1'b0;
    else if (cpu_we && !fifo_push) cpu_ovf <= 1'b1;
  end

endmodule

// File: tb/tb_cram_wr_arb.sv
// tb/tb_cram_wr_arb.sv - scoreboard bench for cram_wr_arb (covers CRAM_INIT_EN when defined)
module tb_cram_wr_arb;

`ifdef CRAM_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [14:0] cpu_data = '0;
  logic        dma_req = 1'b0;
  logic [7:0]  dma_addr = '0;
  logic [14:0] dma_data = '0;
  logic        dma_rdy;
  logic        cram_we;
  logic [7:0]  cram_addr;
  logic [14:0] cram_data;
  logic        init_done;
  logic        cpu_ovf;
  logic        busy;

  cram_wr_arb dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_data  (dma_data),
    .dma_rdy   (dma_rdy),
    .cram_we   (cram_we),
    .cram_addr (cram_addr),
    .cram_data (cram_data),
    .init_done (init_done),
    .cpu_ovf   (cpu_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { int cyc; int addr; int data; } exp_t;
  typedef struct { int addr; int data; } ent_t;

  exp_t exp_q[$];
  ent_t cpu_q[$];
  bit   run_m;
  int   sweep_m;
  bit   ovf_m;
  int   cyc = 0;

  task automatic model_reset();
    run_m   = !INIT_EN;
    sweep_m = 0;
    ovf_m   = 0;
    cpu_q.delete();
    exp_q.delete();
  endtask

  // Reference model: each edge decides which write the port owes, by priority rule.
  always @(posedge clk) begin : model
    bit   rdy_now;
    ent_t e;
    if (!rst) begin
      cyc++;
      rdy_now = run_m && (cpu_q.size() == 0);
      if (!run_m) begin
        exp_q.push_back('{cyc, sweep_m, (sweep_m % 32) * 1057});
        if (sweep_m == 255) run_m = 1;
        sweep_m++;
      end else if (cpu_q.size() > 0) begin
        e = cpu_q.pop_front();
        exp_q.push_back('{cyc, e.addr, e.data});
      end else if (dma_req && rdy_now) begin
        exp_q.push_back('{cyc, int'(dma_addr), int'(dma_data)});
      end
      if (cpu_we) begin
        if (cpu_q.size() < 2) cpu_q.push_back('{int'(cpu_addr), int'(cpu_data)});
        else ovf_m = 1;
      end
    end
  end

  // Monitor: status flags every cycle, and every CRAM write against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      chk("dma_rdy",   int'(dma_rdy),   int'(run_m && cpu_q.size() == 0));
      chk("busy",      int'(busy),      int'(!run_m || cpu_q.size() != 0));
      chk("init_done", int'(init_done), int'(run_m));
      chk("cpu_ovf",   int'(cpu_ovf),   int'(ovf_m));
      if (cram_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", int'(cram_addr), e.addr);
          chk("wr_data", int'(cram_data), e.data);
        end
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          chk("missed_write", 0, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input bit we, input int ca, input int cd,
                      input bit dr, input int da, input int dd);
    @(negedge clk);
    #2;
    cpu_we   = we;
    cpu_addr = 8'(ca);
    cpu_data = 15'(cd);
    dma_req  = dr;
    dma_addr = 8'(da);
    dma_data = 15'(dd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset away from the clock edge, checks the asynchronous clear, then releases.
  task automatic do_reset();
    cpu_we  = 0;
    dma_req = 0;
    rst = 1'b1;
    #1;
    chk("rst_cram_we",   int'(cram_we),   0);
    chk("rst_cram_addr", int'(cram_addr), 0);
    chk("rst_cram_data", int'(cram_data), 0);
    chk("rst_cpu_ovf",   int'(cpu_ovf),   0);
    chk("rst_dma_rdy",   int'(dma_rdy),   int'(!INIT_EN));
    chk("rst_init_done", int'(init_done), int'(!INIT_EN));
    chk("rst_busy",      int'(busy),      int'(INIT_EN));
    model_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #2;
    do_reset();

    if (INIT_EN) begin
      // Three back-to-back CPU writes during the sweep: two queue, the third drops.
      step(1, 'h31, 'h1111, 0, 0, 0);
      step(1, 'h32, 'h2222, 0, 0, 0);
      step(1, 'h33, 'h3333, 0, 0, 0);
      idle(262);
      chk("ovf_sticky", int'(cpu_ovf), 1);
    end else begin
      idle(3);
    end

    // Single uncontended CPU write.
    step(1, 'h10, 'h7fff, 0, 0, 0);
    idle(4);

    // Eight-word DMA burst with req held high.
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 'h80 + i, 'h0100 + i);
    idle(3);

    // CPU strobe on the same edge as a DMA acceptance, DMA kept requesting.
    step(1, 'h20, 'h1234, 1, 'h40, 'h0abc);
    step(0, 0, 0, 1, 'h41, 'h0abd);
    step(0, 0, 0, 1, 'h42, 'h0abe);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 255), $urandom_range(0, 32767),
           $urandom_range(0, 1) == 1, $urandom_range(0, 255), $urandom_range(0, 32767));
    idle(3);

    // Reset in the middle of activity; the sweep (if present) must restart at entry 0.
    if (INIT_EN) begin
      do_reset();
      idle(101);
      #1;
      chk("mid_sweep_addr", int'(cram_addr), 100);
      chk("mid_sweep_we",   int'(cram_we),   1);
      do_reset();
      idle(262);
    end else begin
      for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 'h60 + i, 'h0200 + i);
      #1;
      chk("mid_burst_we", int'(cram_we), 1);
      do_reset();
      idle(2);
    end

    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 255), $urandom_range(0, 32767),
           $urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 32767));
    idle(5);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
